perceptron_train_ctrl: RTL

//   Moore FSM that sequences the single-neuron perceptron datapath through training.
//   Per sample it computes yin = b + w1*x1 + w2*x2 and compares sign(yin) with target t.
//   On a mismatch it applies w += alpha*t*x and b += alpha*t.

---
 rtl/perceptron_train_ctrl_pkg.sv | 47 ++++
 rtl/perceptron_train_ctrl_if.sv | 52 +++++
 rtl/perceptron_train_ctrl_epoch_counter.sv | 34 +++
 rtl/perceptron_train_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/perceptron_train_ctrl_pkg.sv
// Shared definitions for the perceptron training controller and its datapath.
// Holds the controller state encoding and the datapath mux select codes.
package perceptron_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_EPOCH,
    S_FETCH,
    S_MUL1,
    S_ACC1,
    S_ACC2,
    S_CMP,
    S_UPD1,
    S_UPW1,
    S_UPW2,
    S_UPB,
    S_NEXT,
    S_EP_END,
    S_REWIND,
    S_DONE
  } state_t;

  // Adder operand A
  localparam logic [1:0] SEL_SUM1_B   = 2'b00;
  localparam logic [1:0] SEL_SUM1_W1  = 2'b01;
  localparam logic [1:0] SEL_SUM1_W2  = 2'b10;
  localparam logic [1:0] SEL_SUM1_YIN = 2'b11;

  // Adder operand B
  localparam logic SEL_SUM2_ALPHA = 1'b0;
  localparam logic SEL_SUM2_TMP   = 1'b1;

  // Multiplier operand A
  localparam logic [1:0] SEL_MULT1_ALPHA = 2'b00;
  localparam logic [1:0] SEL_MULT1_W1    = 2'b01;
  localparam logic [1:0] SEL_MULT1_W2    = 2'b10;

  // Multiplier operand B
  localparam logic SEL_MULT2_X1 = 1'b0;
  localparam logic SEL_MULT2_X2 = 1'b1;

  // yin register source
  localparam logic SEL_YIN_B   = 1'b0;
  localparam logic SEL_YIN_SUM = 1'b1;

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Bundle between the training controller (master) and the datapath/host (slave).
//   start/busy/done/converged/epoch_cnt : host handshake and result
//   equal/flag_out/EOF/t1_out           : datapath status
//   ld_*/rst_flag/set_flag/init_*/next/sub/sel_* : datapath controls
interface perceptron_train_ctrl_if #(
  parameter int unsigned EPW = 5
);
  logic           start;
  logic           busy;
  logic           done;
  logic           converged;
  logic [EPW-1:0] epoch_cnt;

  logic equal;
  logic flag_out;
  logic EOF;
  logic t1_out;

  logic ld_b;
  logic ld_w1;
  logic ld_w2;
  logic ld_tmp;
  logic ld_yin;
  logic rst_flag;
  logic set_flag;
  logic init_all_reg;
  logic init_file_handler;
  logic next;
  logic sub;
  logic sel_sum2;
  logic sel_mult2;
  logic sel_yin;
  logic [1:0] sel_sum1;
  logic [1:0] sel_mult1;

  modport master (
    input  start, equal, flag_out, EOF, t1_out,
    output busy, done, converged, epoch_cnt,
    output ld_b, ld_w1, ld_w2, ld_tmp, ld_yin, rst_flag, set_flag,
    output init_all_reg, init_file_handler, next, sub,
    output sel_sum2, sel_mult2, sel_yin, sel_sum1, sel_mult1
  );

  modport slave (
    output start, equal, flag_out, EOF, t1_out,
    input  busy, done, converged, epoch_cnt,
    input  ld_b, ld_w1, ld_w2, ld_tmp, ld_yin, rst_flag, set_flag,
    input  init_all_reg, init_file_handler, next, sub,
    input  sel_sum2, sel_mult2, sel_yin, sel_sum1, sel_mult1
  );

endinterface

// File: rtl/perceptron_train_ctrl_epoch_counter.sv
// Completed-epoch counter.
//   clk, rst : clock, async active-low reset
//   clr      : synchronous clear
//   inc      : count one completed epoch (saturates at MAX_EPOCHS)
//   cnt      : registered count
//   last_c   : the next increment reaches (or count already sits at) MAX_EPOCHS
module epoch_counter #(
  parameter int unsigned MAX_EPOCHS = 16,
  parameter int unsigned EPW        = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           inc,
  output logic [EPW-1:0] cnt,
  output logic           last_c
);

  localparam logic [EPW-1:0] MAX_V  = EPW'(MAX_EPOCHS);
  localparam logic [EPW-1:0] LAST_V = EPW'(MAX_EPOCHS - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + EPW'(1);
    end
  end

  assign last_c = (cnt >= LAST_V);

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Moore controller sequencing a single-neuron perceptron datapath through training.
// Per sample: yin = b + w1*x1 + w2*x2; on sign mismatch w += alpha*t*x, b += alpha*t.
// Epochs repeat until an epoch makes no update or MAX_EPOCHS epochs have updated.
//   clk, rst : clock, async active-low reset
//   bus      : master side of perceptron_train_ctrl_if (handshake, DP status, DP controls)
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int unsigned MAX_EPOCHS = 16,
  parameter int unsigned EPW        = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  perceptron_train_ctrl_if.master bus
);

  state_t         state;
  state_t         state_nxt;
  logic           cnt_clr;
  logic           cnt_inc;
  logic           cnt_last_c;
  logic [EPW-1:0] epoch_cnt;
  logic           converged;

  epoch_counter #(
    .MAX_EPOCHS(MAX_EPOCHS),
    .EPW       (EPW)
  ) u_epoch_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (epoch_cnt),
    .last_c(cnt_last_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Convergence result: cleared on (re)start, captured when an epoch ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   converged <= 1'b0;
    else if (state == S_INIT)   converged <= 1'b0;
    else if (state == S_EP_END) converged <= !bus.flag_out;
  end

  assign bus.epoch_cnt = epoch_cnt;
  assign bus.converged = converged;

  // Next-state and datapath control decode
  always_comb begin
    state_nxt             = state;
    cnt_clr               = 1'b0;
    cnt_inc               = 1'b0;
    bus.busy              = 1'b1;
    bus.done              = 1'b0;
    bus.ld_b              = 1'b0;
    bus.ld_w1             = 1'b0;
    bus.ld_w2             = 1'b0;
    bus.ld_tmp            = 1'b0;
    bus.ld_yin            = 1'b0;
    bus.rst_flag          = 1'b0;
    bus.set_flag          = 1'b0;
    bus.init_all_reg      = 1'b0;
    bus.init_file_handler = 1'b0;
    bus.next              = 1'b0;
    bus.sub               = 1'b0;
    bus.sel_sum1          = SEL_SUM1_B;
    bus.sel_sum2          = SEL_SUM2_ALPHA;
    bus.sel_mult1         = SEL_MULT1_ALPHA;
    bus.sel_mult2         = SEL_MULT2_X1;
    bus.sel_yin           = SEL_YIN_B;

    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = S_INIT;
      end
      S_INIT: begin
        bus.init_all_reg      = 1'b1;
        bus.init_file_handler = 1'b1;
        cnt_clr               = 1'b1;
        state_nxt             = S_EPOCH;
      end
      S_EPOCH: begin
        bus.rst_flag = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = bus.EOF ? S_EP_END : S_MUL1;
      end
      S_MUL1: begin
        bus.ld_tmp    = 1'b1;
        bus.sel_mult1 = SEL_MULT1_W1;
        bus.sel_mult2 = SEL_MULT2_X1;
        bus.ld_yin    = 1'b1;
        bus.sel_yin   = SEL_YIN_B;
        state_nxt     = S_ACC1;
      end
      S_ACC1: begin
        // yin += w1*x1 uses the old tmp while tmp loads w2*x2 on the same edge
        bus.ld_yin    = 1'b1;
        bus.sel_sum1  = SEL_SUM1_YIN;
        bus.sel_sum2  = SEL_SUM2_TMP;
        bus.sel_yin   = SEL_YIN_SUM;
        bus.ld_tmp    = 1'b1;
        bus.sel_mult1 = SEL_MULT1_W2;
        bus.sel_mult2 = SEL_MULT2_X2;
        state_nxt     = S_ACC2;
      end
      S_ACC2: begin
        bus.ld_yin   = 1'b1;
        bus.sel_sum1 = SEL_SUM1_YIN;
        bus.sel_sum2 = SEL_SUM2_TMP;
        bus.sel_yin  = SEL_YIN_SUM;
        state_nxt    = S_CMP;
      end
      S_CMP: begin
        state_nxt = bus.equal ? S_NEXT : S_UPD1;
      end
      S_UPD1: begin
        bus.ld_tmp    = 1'b1;
        bus.sel_mult1 = SEL_MULT1_ALPHA;
        bus.sel_mult2 = SEL_MULT2_X1;
        state_nxt     = S_UPW1;
      end
      S_UPW1: begin
        // Negative target subtracts the correction
        bus.ld_w1     = 1'b1;
        bus.sel_sum1  = SEL_SUM1_W1;
        bus.sel_sum2  = SEL_SUM2_TMP;
        bus.sub       = bus.t1_out;
        bus.ld_tmp    = 1'b1;
        bus.sel_mult1 = SEL_MULT1_ALPHA;
        bus.sel_mult2 = SEL_MULT2_X2;
        state_nxt     = S_UPW2;
      end
      S_UPW2: begin
        bus.ld_w2    = 1'b1;
        bus.sel_sum1 = SEL_SUM1_W2;
        bus.sel_sum2 = SEL_SUM2_TMP;
        bus.sub      = bus.t1_out;
        state_nxt    = S_UPB;
      end
      S_UPB: begin
        bus.ld_b     = 1'b1;
        bus.sel_sum1 = SEL_SUM1_B;
        bus.sel_sum2 = SEL_SUM2_ALPHA;
        bus.sub      = bus.t1_out;
        bus.set_flag = 1'b1;
        state_nxt    = S_NEXT;
      end
      S_NEXT: begin
        bus.next  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EP_END: begin
        if (!bus.flag_out) begin
          state_nxt = S_DONE;
        end else begin
          cnt_inc   = 1'b1;
          state_nxt = cnt_last_c ? S_DONE : S_REWIND;
        end
      end
      S_REWIND: begin
        bus.init_file_handler = 1'b1;
        state_nxt             = S_EPOCH;
      end
      S_DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
        if (bus.start) state_nxt = S_INIT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
